// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM encodings and default operand width.
package serial_adder_pkg;

  localparam int unsigned SA_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } sa_state_e;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_full_adder.sv
// Single-bit full adder cell shared by the serial adder datapath.
module full_adder (
  output logic s,
  output logic c,
  input  logic a,
  input  logic b,
  input  logic cin
);

  logic p;

  always_comb begin
    p = a ^ b;
    s = p ^ cin;
    c = (a & b) | (cin & p);
  end

endmodule : full_adder

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder cell plus a carry flop, LSB first, one bit per clock.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = SA_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  sa_state_e        state_q,  state_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             carry_q,  carry_d;
  logic [WIDTH-1:0] a_sr_q,   a_sr_d;
  logic [WIDTH-1:0] b_sr_q,   b_sr_d;
  logic [WIDTH-1:0] res_sr_q, res_sr_d;
  logic [WIDTH-1:0] sum_q,    sum_d;
  logic             cout_q,   cout_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;

  logic fa_s;
  logic fa_c;

  full_adder FA0 (
    .s   (fa_s),
    .c   (fa_c),
    .a   (a_sr_q[0]),
    .b   (b_sr_q[0]),
    .cin (carry_q)
  );

  // Next-state and datapath sequencing
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    carry_d  = carry_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_sr_d = res_sr_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          carry_d = cin;
          count_d = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        res_sr_d = WIDTH'({fa_s, res_sr_q} >> 1);
        carry_d  = fa_c;
        if (count_q == CNT_W'(WIDTH - 1)) begin
          // Last bit: the freshly shifted result is the final sum
          sum_d   = WIDTH'({fa_s, res_sr_q} >> 1);
          cout_d  = fa_c;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          count_d = count_q + CNT_W'(1);
          busy_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      carry_q  <= 1'b0;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      carry_q  <= carry_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_sr_q <= res_sr_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Directed and streaming checks of serial_adder at WIDTH=8 and WIDTH=16.
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start8,  cin8,  busy8,  done8,  cout8;
  logic [7:0]  a8, b8, sum8;
  logic        start16, cin16, busy16, done16, cout16;
  logic [15:0] a16, b16, sum16;

  int n_vec = 0;
  int n_err = 0;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .cin(cin16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // One WIDTH=8 op; optionally pulse start with new operands at busy cycle 'poke'
  task automatic op8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                     input logic ci, input logic [8:0] exp, input int poke);
    @(negedge clk);
    start8 = 1'b1; a8 = av; b8 = bv; cin8 = ci;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      start8 = (i == poke);
      if (i == poke) begin
        a8 = 8'h11; b8 = 8'h22;
      end
      check({tag, " busy"}, 32'(busy8), 32'd1);
      check({tag, " no done"}, 32'(done8), 32'd0);
    end
    @(negedge clk);
    start8 = 1'b0;
    check({tag, " done"}, 32'(done8), 32'd1);
    check({tag, " busy off"}, 32'(busy8), 32'd0);
    check({tag, " result"}, 32'({cout8, sum8}), 32'(exp));
    @(negedge clk);
    check({tag, " done drop"}, 32'(done8), 32'd0);
    check({tag, " result held"}, 32'({cout8, sum8}), 32'(exp));
  endtask

  task automatic drive(input int w, input logic s, input logic [15:0] av,
                       input logic [15:0] bv, input logic ci);
    if (w == 8) begin
      start8 = s; a8 = av[7:0]; b8 = bv[7:0]; cin8 = ci;
    end else begin
      start16 = s; a16 = av; b16 = bv; cin16 = ci;
    end
  endtask

  function automatic logic [16:0] model(input int w, input logic [15:0] av,
                                        input logic [15:0] bv, input logic ci);
    if (w == 8) return 17'(av[7:0]) + 17'(bv[7:0]) + 17'(ci);
    return 17'(av) + 17'(bv) + 17'(ci);
  endfunction

  // Start held high: back-to-back random ops, checking spacing and results
  task automatic stream(input int w);
    logic [15:0] av, bv;
    logic        ci, dn;
    logic [16:0] res;
    logic [16:0] expq[$];
    int          since, got, extra;
    av = 16'($urandom); bv = 16'($urandom); ci = 1'($urandom);
    @(negedge clk);
    drive(w, 1'b1, av, bv, ci);
    expq.push_back(model(w, av, bv, ci));
    since = 0; got = 0;
    while (got < 200) begin
      @(negedge clk);
      since++;
      dn  = (w == 8) ? done8 : done16;
      res = (w == 8) ? {8'b0, cout8, sum8} : {cout16, sum16};
      if (dn) begin
        if (got == 0) check($sformatf("w%0d latency", w), 32'(since), 32'(w + 1));
        else          check($sformatf("w%0d interval", w), 32'(since), 32'(w + 2));
        check($sformatf("w%0d result %0d", w, got), 32'(res), 32'(expq.pop_front()));
        got++; since = 0;
        if (got < 200) begin
          av = 16'($urandom); bv = 16'($urandom); ci = 1'($urandom);
          drive(w, 1'b1, av, bv, ci);
          expq.push_back(model(w, av, bv, ci));
        end else begin
          drive(w, 1'b0, 16'h0, 16'h0, 1'b0);
        end
      end else if (since > w + 4) begin
        check($sformatf("w%0d done timeout", w), 32'(since), 32'(w + 2));
        got = 200;
        drive(w, 1'b0, 16'h0, 16'h0, 1'b0);
      end
    end
    extra = 0;
    repeat (w + 4) begin
      @(negedge clk);
      if (((w == 8) ? done8 : done16) == 1'b1) extra++;
    end
    check($sformatf("w%0d quiet after stream", w), 32'(extra), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
    repeat (2) @(negedge clk);
    check("reset busy", 32'(busy8), 32'd0);
    check("reset done", 32'(done8), 32'd0);
    check("reset result", 32'({cout8, sum8}), 32'd0);
    check("reset result w16", 32'({cout16, sum16}), 32'd0);
    rst = 1'b0;

    op8("3c+05",    8'h3C, 8'h05, 1'b0, 9'h041, -1);
    op8("ff+01",    8'hFF, 8'h01, 1'b0, 9'h100, -1);
    op8("ff+ff+1",  8'hFF, 8'hFF, 1'b1, 9'h1FF, -1);
    op8("zero",     8'h00, 8'h00, 1'b0, 9'h000, -1);
    op8("ignore start", 8'h3C, 8'h05, 1'b0, 9'h041, 2);

    // Abort with reset at busy cycle 4
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start8 = 1'b0;
      check("abort pre busy", 32'(busy8), 32'd1);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", 32'(busy8), 32'd0);
    check("abort done", 32'(done8), 32'd0);
    check("abort result", 32'({cout8, sum8}), 32'd0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("abort no done", 32'(done8), 32'd0);
    end
    op8("after abort", 8'h12, 8'h34, 1'b1, 9'h047, -1);

    stream(8);
    stream(16);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_serial_adder
